// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
//
// Hazard and forwarding control for the MIPS pipeline. It sits beside ID and
// remembers the destination of every instruction that left ID during the last
// DEPTH cycles. Slot 0 is EX, slot 1 is MEM, and so on. From that history it
// produces the load-use stall, the forwarding select for each operand, and the
// bubble that replaces the ID instruction when a branch is taken.
//
// Parameters
//   DEPTH       number of tracked post-ID slots (1..7)
//   REG_ADDR_W  register address width
//   LOAD_LAT    a load in slot k < LOAD_LAT has no data yet, so a reader stalls
//   SEL_W       width of the forwarding selects and of in_flight (derived)
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   id_*              decoded fields of the instruction currently in ID
//   branch_taken      branch resolved taken in EX; the ID instruction is dropped
//   stall             hold PC and IF/ID and put a bubble into ID/EX (combinational)
//   fwd_rs_sel/rt_sel 0 = register file; k+1 = result from slot k
//   stall_cycles      saturating count of stalled cycles    (STATS build only)
//   flush_cycles      saturating count of flushed ID slots  (STATS build only)
//   in_flight         registered count of valid, writing slots
//
// Build option
//   PIPE_SCOREBOARD_STATS_EN adds the stall_cycles and flush_cycles counters.
// -----------------------------------------------------------------------------
module pipe_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_rs_sel,
  output logic [SEL_W-1:0]      fwd_rt_sel,
`ifdef PIPE_SCOREBOARD_STATS_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_cycles,
`endif
  output logic [SEL_W-1:0]      in_flight
);

  // Slot state. Each slot holds {valid, write, is_load, dest}.
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      write_q, write_d;
  logic [DEPTH-1:0]      load_q,  load_d;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [REG_ADDR_W-1:0] dest_d [DEPTH];
  logic [SEL_W-1:0]      in_flight_q, in_flight_d;

  // A per-slot compare against each source operand.
  logic [DEPTH-1:0] hit_rs;
  logic [DEPTH-1:0] hit_rt;
  // This slot holds a load whose data cannot be forwarded yet.
  logic [DEPTH-1:0] early_load;

  // Result of the priority search, before reset, stall and branch are applied.
  logic             rs_found, rt_found;
  logic             rs_stall, rt_stall;
  logic [SEL_W-1:0] rs_sel_raw, rt_sel_raw;
  logic             stall_raw;
  logic             take_id;

  genvar gi;

  // Register 0 is hard-wired to zero. It never matches, so it can never
  // stall or forward.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign hit_rs[gi] = id_uses_rs && (id_rs != '0) && valid_q[gi] &&
                          write_q[gi] && (dest_q[gi] == id_rs);
      assign hit_rt[gi] = id_uses_rt && (id_rt != '0) && valid_q[gi] &&
                          write_q[gi] && (dest_q[gi] == id_rt);
      // With LOAD_LAT = 0 this term is constant 0, so loads forward like
      // ALU results.
      if (gi < LOAD_LAT) begin : g_early
        assign early_load[gi] = load_q[gi];
      end else begin : g_late
        assign early_load[gi] = 1'b0;
      end
    end
  endgenerate

  // The loop runs from the oldest slot to the youngest, so the lowest matching
  // slot writes last and wins. The youngest producer is the one that counts.
  always_comb begin
    rs_found   = 1'b0;
    rt_found   = 1'b0;
    rs_stall   = 1'b0;
    rt_stall   = 1'b0;
    rs_sel_raw = '0;
    rt_sel_raw = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_rs[k]) begin
        rs_found   = 1'b1;
        rs_stall   = early_load[k];
        rs_sel_raw = SEL_W'(k + 1);
      end
      if (hit_rt[k]) begin
        rt_found   = 1'b1;
        rt_stall   = early_load[k];
        rt_sel_raw = SEL_W'(k + 1);
      end
    end
  end

  // Reset and a taken branch both override the stall. The instruction in ID
  // is discarded anyway, so holding the front end would only lose a cycle.
  assign stall_raw = rs_stall || rt_stall;
  assign stall     = !RST && !branch_taken && stall_raw;

  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    if (!RST && !stall) begin
      if (rs_found) fwd_rs_sel = rs_sel_raw;
      if (rt_found) fwd_rt_sel = rt_sel_raw;
    end
  end

  // Slot 0 takes the ID instruction only when it really advances. In every
  // other case it takes a bubble.
  assign take_id = id_valid && !stall && !branch_taken;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign valid_d[gi] = take_id;
        assign write_d[gi] = take_id && id_reg_write;
        assign load_d[gi]  = take_id && id_is_load;
        assign dest_d[gi]  = take_id ? id_dest : '0;
      end else begin : g_body
        assign valid_d[gi] = valid_q[gi-1];
        assign write_d[gi] = write_q[gi-1];
        assign load_d[gi]  = load_q[gi-1];
        assign dest_d[gi]  = dest_q[gi-1];
      end
    end
  endgenerate

  // The count is taken from the next slot contents. The registered value then
  // always matches the slots held in the same cycle.
  always_comb begin
    in_flight_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      in_flight_d = in_flight_d + SEL_W'(valid_d[k] && write_d[k]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= '0;
      write_q     <= '0;
      load_q      <= '0;
      in_flight_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      write_q     <= write_d;
      load_q      <= load_d;
      in_flight_q <= in_flight_d;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

  assign in_flight = in_flight_q;

`ifdef PIPE_SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_cycles_q, flush_cycles_d;

  // Both counters stop at all-ones and do not wrap.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    if (branch_taken && id_valid && (flush_cycles_q != 16'hFFFF)) begin
      flush_cycles_d = flush_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipe_scoreboard
//
// Directed bench for pipe_scoreboard. All instances share one set of ID inputs:
//   u_dut   DEPTH=3, LOAD_LAT=1  (main instance)
//   u_lat2  DEPTH=3, LOAD_LAT=2  (longer load latency)
//   u_stat  DEPTH=7, LOAD_LAT=7  (STATS build only; stalls almost every cycle)
//
// Each step drives the ID inputs and pushes the expected outputs onto a queue.
// At the following falling edge the bench pops the queue and compares each
// entry with the DUT output it names.
// -----------------------------------------------------------------------------
module tb_pipe_scoreboard;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
  logic       branch_taken;

  logic       s1, s2;
  logic [1:0] rs1, rt1, inf1, rs2, rt2, inf2;
`ifdef PIPE_SCOREBOARD_STATS_EN
  logic        s3;
  logic [2:0]  rs3, rt3, inf3;
  logic [15:0] sc1, fc1, sc2, fc2, sc3, fc3;
`endif

  pipe_scoreboard #(.DEPTH(3), .REG_ADDR_W(5), .LOAD_LAT(1)) u_dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .stall(s1), .fwd_rs_sel(rs1), .fwd_rt_sel(rt1),
`ifdef PIPE_SCOREBOARD_STATS_EN
    .stall_cycles(sc1), .flush_cycles(fc1),
`endif
    .in_flight(inf1)
  );

  pipe_scoreboard #(.DEPTH(3), .REG_ADDR_W(5), .LOAD_LAT(2)) u_lat2 (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .stall(s2), .fwd_rs_sel(rs2), .fwd_rt_sel(rt2),
`ifdef PIPE_SCOREBOARD_STATS_EN
    .stall_cycles(sc2), .flush_cycles(fc2),
`endif
    .in_flight(inf2)
  );

`ifdef PIPE_SCOREBOARD_STATS_EN
  pipe_scoreboard #(.DEPTH(7), .REG_ADDR_W(5), .LOAD_LAT(7)) u_stat (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .stall(s3), .fwd_rs_sel(rs3), .fwd_rt_sel(rt3),
    .stall_cycles(sc3), .flush_cycles(fc3),
    .in_flight(inf3)
  );
`endif

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Signal selector: 0..3 main stall/rs/rt/in_flight, 4..6 lat2 stall/rs/rt,
  // 7..8 stats counters of u_stat.
  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0: return 32'(s1);
      1: return 32'(rs1);
      2: return 32'(rt1);
      3: return 32'(inf1);
      4: return 32'(s2);
      5: return 32'(rs2);
      6: return 32'(rt2);
`ifdef PIPE_SCOREBOARD_STATS_EN
      7: return 32'(sc3);
      8: return 32'(fc3);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, o, e.val);
      end
      $display("check %-22s sig=%0d observed=%0d expected=%0d", e.tag, e.sig, o, e.val);
    end
  endtask

  task automatic exp_main(input string tag, input int s, input int rs,
                          input int rt, input int inf);
    push_exp({tag, "/stall"}, 0, s);
    push_exp({tag, "/rs"}, 1, rs);
    push_exp({tag, "/rt"}, 2, rt);
    push_exp({tag, "/in_flight"}, 3, inf);
  endtask

  task automatic exp_lat2(input string tag, input int s, input int rs, input int rt);
    push_exp({tag, "/l2_stall"}, 4, s);
    push_exp({tag, "/l2_rs"}, 5, rs);
    push_exp({tag, "/l2_rt"}, 6, rt);
  endtask

  task automatic id(input bit v, input int rs, input bit urs, input int rt,
                    input bit urt, input int dest, input bit rw, input bit ld);
    id_valid     = v;
    id_rs        = 5'(rs);
    id_uses_rs   = urs;
    id_rt        = 5'(rt);
    id_uses_rt   = urt;
    id_dest      = 5'(dest);
    id_reg_write = rw;
    id_is_load   = ld;
  endtask

  // Compare at the falling edge, then advance one cycle and drive the next
  // step 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST          = 1'b1;
    branch_taken = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;

    // Reset held while ID offers a real writer of r3.
    id(1, 3, 1, 0, 0, 3, 1, 0);
    exp_main("rst1", 0, 0, 0, 0); cyc();
    exp_main("rst2", 0, 0, 0, 0); cyc();
    RST = 1'b0;

    // ALU forwarding at distances 1, 2 and 3, then out of range.
    id(1, 0, 0, 0, 0, 3, 1, 0); exp_main("post_rst_w3", 0, 0, 0, 0); cyc();
    id(1, 3, 1, 0, 0, 0, 0, 0); exp_main("fwd_d1", 0, 1, 0, 1); cyc();
    id(1, 3, 0, 3, 1, 0, 0, 0); exp_main("fwd_d2_rs_unused", 0, 0, 2, 1); cyc();
    id(1, 3, 1, 3, 1, 0, 0, 0); exp_main("fwd_d3", 0, 3, 3, 1); cyc();
    id(1, 3, 1, 0, 0, 0, 0, 0); exp_main("fwd_gone", 0, 0, 0, 0); cyc();

    // Load-use. LOAD_LAT=1 stalls one cycle; LOAD_LAT=2 stalls two.
    id(1, 0, 0, 0, 0, 5, 1, 1);
    exp_main("lw5", 0, 0, 0, 0); exp_lat2("lw5", 0, 0, 0); cyc();
    id(1, 0, 0, 5, 1, 0, 0, 0);
    exp_main("lu_c1", 1, 0, 0, 1); exp_lat2("lu_c1", 1, 0, 0); cyc();
    exp_main("lu_c2", 0, 0, 2, 1); exp_lat2("lu_c2", 1, 0, 0); cyc();
    exp_main("lu_c3_repeat", 0, 0, 3, 1); exp_lat2("lu_c3", 0, 0, 3); cyc();

    // Bring both instances back into step.
    RST = 1'b1;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_main("resync", 0, 0, 0, 0); cyc();
    RST = 1'b0;

    // Youngest writer wins; r0 never matches, even from a load.
    id(1, 0, 0, 0, 0, 7, 1, 0); exp_main("w7a", 0, 0, 0, 0); cyc();
    id(1, 0, 0, 0, 0, 7, 1, 0); exp_main("w7b", 0, 0, 0, 1); cyc();
    id(1, 7, 1, 0, 0, 0, 0, 0); exp_main("rd7_youngest", 0, 1, 0, 2); cyc();
    id(1, 0, 0, 0, 0, 0, 1, 0); exp_main("w0", 0, 0, 0, 2); cyc();
    id(1, 0, 1, 0, 1, 0, 0, 0); exp_main("rd0", 0, 0, 0, 2); cyc();
    id(1, 0, 0, 0, 0, 0, 1, 1); exp_main("lw0", 0, 0, 0, 1); cyc();
    id(1, 0, 1, 0, 1, 0, 0, 0);
    exp_main("rd0_after_lw0", 0, 0, 0, 2); exp_lat2("rd0_after_lw0", 0, 0, 0); cyc();

    // A taken branch wins over the stall; the ID writer must not enter.
    id(1, 0, 0, 0, 0, 4, 1, 1); exp_main("lw4", 0, 0, 0, 1); cyc();
    id(1, 4, 1, 0, 0, 9, 1, 0);
    branch_taken = 1'b1;
    push_exp("flush/stall", 0, 0);
    push_exp("flush/in_flight", 3, 2);
    push_exp("flush/l2_stall", 4, 0);
    cyc();
    branch_taken = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    exp_main("flush_after", 0, 0, 0, 1); cyc();
    exp_main("flush_drain", 0, 0, 0, 1); cyc();
    exp_main("flush_empty", 0, 0, 0, 0); cyc();

    // Reset during a stall cancels it at once and empties the scoreboard.
    id(1, 0, 0, 0, 0, 6, 1, 1); exp_main("lw6", 0, 0, 0, 0); cyc();
    id(1, 6, 1, 0, 0, 0, 0, 0); exp_main("stall_pre_rst", 1, 0, 0, 1); cyc();
    RST = 1'b1;
    exp_main("rst_mid", 0, 0, 0, 1); exp_lat2("rst_mid", 0, 0, 0); cyc();
    RST = 1'b0;
    exp_main("after_rst_mid", 0, 0, 0, 0); exp_lat2("after_rst_mid", 0, 0, 0); cyc();

`ifdef PIPE_SCOREBOARD_STATS_EN
    // With DEPTH=7 and LOAD_LAT=7, a load that reads its own destination
    // enters once and then stalls 7 cycles. That is 7 stalls per 8 cycles.
    RST = 1'b1;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    id(1, 5, 1, 0, 0, 5, 1, 1);
    repeat (8000) @(posedge CLK);
    #1;
    push_exp("stat_stall_7000", 7, 7000);
    push_exp("stat_flush_0", 8, 0);
    check_all();
    repeat (72000) @(posedge CLK);
    #1;
    push_exp("stat_stall_sat", 7, 16'hFFFF);
    check_all();
    branch_taken = 1'b1;
    @(posedge CLK);
    #1;
    branch_taken = 1'b0;
    push_exp("stat_flush_1", 8, 1);
    push_exp("stat_stall_held", 7, 16'hFFFF);
    check_all();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    push_exp("stat_stall_rst", 7, 0);
    push_exp("stat_flush_rst", 8, 0);
    check_all();
    RST = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard/forwarding control block for the MIPS pipeline, sitting beside ID_Stage and feeding the ID/EX register and EX operand muxes.
- Tracks the destination register of every instruction in flight for DEPTH stages after ID (slot 0 = EX, slot 1 = MEM, ...).
- Produces the load-use stall, per-operand forwarding selects and branch-flush bubbles; generalises a fixed 3-stage datapath to arbitrary depth and load latency.

Parameters:
- DEPTH, 3, number of tracked post-ID slots (EX, MEM, WB by default); range 1..7
- REG_ADDR_W, 5, register address width
- LOAD_LAT, 1, a load in slot k < LOAD_LAT cannot forward yet and forces a stall; range 0..DEPTH
- SEL_W, $clog2(DEPTH+1), width of the forwarding selects (derived)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs  input  REG_ADDR_W  source register 1
- id_rt  input  REG_ADDR_W  source register 2
- id_uses_rs  input  1  instruction reads rs
- id_uses_rt  input  1  instruction reads rt
- id_dest  input  REG_ADDR_W  destination register
- id_reg_write  input  1  instruction writes id_dest
- id_is_load  input  1  instruction is a load
- branch_taken  input  1  branch resolved taken in EX this cycle
- stall  output  1  hold PC and IF/ID and insert a bubble into ID/EX (combinational)
- fwd_rs_sel  output  SEL_W  0 = register file; k+1 = result from slot k
- fwd_rt_sel  output  SEL_W  as fwd_rs_sel, for rt
- in_flight  output  SEL_W  count of valid writing slots (registered)

Behaviour:
- Each slot holds {valid, write, is_load, dest}.
- Every edge, slots shift: slot k+1 <= slot k; the contents of slot DEPTH-1 retire.
- Slot 0 loading:
  - slot 0 <= ID instruction when id_valid && !stall && !branch_taken;
  - otherwise slot 0 <= bubble (valid = 0).
- Match rule for each used source s:
  - find the lowest k with valid && write && dest == s && s != 0; youngest wins.
  - No match, or the source is unused: select = 0.
- Stall rule: stall = 1 if a used source matches slot k with is_load && k < LOAD_LAT.
- Forwarding: otherwise select = k+1. While stall = 1, selects are don't-care but held at 0.
- Register 0 never matches, never stalls, never forwards.
- branch_taken:
  - the ID instruction is discarded (bubble into slot 0);
  - stall is forced 0 that cycle, so the branch wins over the stall;
  - older slots are unaffected.
- Stall bubble: the stalled instruction stays in ID, the bubble shifts down the slots, and stall clears when the load reaches slot LOAD_LAT. Latency is LOAD_LAT − k stall cycles.
- LOAD_LAT = 0: loads are treated like ALU results and no stall is ever raised.
- Reset:
  - all slots invalid, in_flight = 0, counters 0;
  - while RST = 1, stall = 0 and selects = 0 regardless of inputs.
  - Reset asserted mid-stall cancels the stall on the same cycle and empties the scoreboard on the next edge.
- in_flight: registered popcount of valid && write over all slots; never exceeds DEPTH.

Optional Feature:
- Macro: PIPE_SCOREBOARD_STATS_EN.
- When defined, adds outputs stall_cycles [15:0] and flush_cycles [15:0]:
  - stall_cycles counts cycles with stall = 1;
  - flush_cycles counts cycles with branch_taken = 1 && id_valid = 1;
  - both saturate at 16'hFFFF and are cleared by RST.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: RST = 1 for 2 cycles with id_valid = 1, id_dest = 3, id_reg_write = 1, then drop RST → stall = 0, fwd selects = 0, in_flight = 0 at first cycle after reset.
- ALU forward (DEPTH = 3): add r3 ← ..., next cycle add reading rs = 3 → fwd_rs_sel = 1, stall = 0. Repeat the read one cycle later with an intervening nop → fwd_rs_sel = 2. Read two cycles after the nop → 3. Later → 0.
- Load-use (LOAD_LAT = 1): lw r5, then an instruction reading rt = 5 → stall = 1 for exactly 1 cycle, then fwd_rt_sel = 2, stall = 0. Repeat with LOAD_LAT = 2 → 2 stall cycles, then sel = 3.
- Priority: writers of r7 in consecutive cycles, then a reader of r7 → fwd_rs_sel = 1 (youngest). A writer to r0 followed by a reader of r0 → sel = 0, stall = 0.
- Flush over stall: lw r4 in slot 0, ID reads r4, branch_taken = 1 the same cycle → stall = 0, slot 0 becomes a bubble, and in_flight does not increment for the ID instruction.
- Stats (PIPE_SCOREBOARD_STATS_EN): force 70000 stall cycles → stall_cycles = 16'hFFFF. Assert RST → 0 after one edge.
